// File: rtl/plat_landing_scan_pkg.sv
// Constants and state encoding shared by the landing scanner and the blocks
// around it (platform generator, character physics).
package plat_landing_scan_pkg;

  localparam int N_PLAT   = 7;
  localparam int POS_W    = 14;
  localparam int LEN_W    = 4;
  localparam int BLOCK_PX = 16;
  localparam int CHAR_W   = 16;
  localparam int VY_W     = 6;
  localparam int IDX_W    = 3;
  localparam int BLOCK_SH = $clog2(BLOCK_PX);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DONE
  } scan_state_t;

endpackage

// File: rtl/plat_slot_check.sv
// Combinational landing test of the character against a single platform slot.
module plat_slot_check
  import plat_landing_scan_pkg::*;
(
  input  logic        [POS_W-1:0] char_x,
  input  logic        [POS_W-1:0] char_y,
  input  logic signed [VY_W-1:0]  char_vy,
  input  logic        [POS_W-1:0] px,
  input  logic        [POS_W-1:0] py,
  input  logic        [LEN_W-1:0] len,
  output logic                    hit,
  output logic        [POS_W-1:0] top
);

  localparam logic [POS_W:0] CHAR_W_X = (POS_W+1)'(CHAR_W);

  logic        [POS_W:0] char_l;
  logic        [POS_W:0] char_r;
  logic        [POS_W:0] plat_l;
  logic        [POS_W:0] plat_r;
  logic signed [POS_W:0] y_next;
  logic signed [POS_W:0] top_s;

  // One extra bit keeps right-edge sums from wrapping near the top of the range.
  assign char_l = {1'b0, char_x};
  assign char_r = char_l + CHAR_W_X;
  assign plat_l = {1'b0, px};
  assign plat_r = plat_l + ((POS_W+1)'(len) << BLOCK_SH);

  // A fall below zero goes negative here and so crosses every top.
  assign y_next = $signed({1'b0, char_y})
                + $signed({{(POS_W+1-VY_W){char_vy[VY_W-1]}}, char_vy});
  assign top_s  = $signed({1'b0, py});

  assign hit = (len != '0)
            && char_vy[VY_W-1]
            && (char_r > plat_l)
            && (char_l < plat_r)
            && (char_y >= py)
            && (y_next <= top_s);

  assign top = py;

endmodule

// File: rtl/plat_landing_scan.sv
// Sequential landing scanner: snapshots the platform list on start, tests one
// slot per clock and reports the highest platform the character lands on.
module plat_landing_scan
  import plat_landing_scan_pkg::*;
(
  input  logic                      sys_clk,
  input  logic                      sys_rst,
  input  logic                      start,
  input  logic        [POS_W-1:0]   char_x,
  input  logic        [POS_W-1:0]   char_y,
  input  logic signed [VY_W-1:0]    char_vy,
  input  logic [N_PLAT*POS_W-1:0]   plat_abs_x,
  input  logic [N_PLAT*POS_W-1:0]   plat_abs_y,
  input  logic [N_PLAT*LEN_W-1:0]   plat_len,
  output logic                      busy,
  output logic                      done,
  output logic                      land_hit,
  output logic        [POS_W-1:0]   land_y,
  output logic        [IDX_W-1:0]   land_idx
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PLAT-1);

  scan_state_t state, state_next;

  logic        [POS_W-1:0]        snap_cx;
  logic        [POS_W-1:0]        snap_cy;
  logic signed [VY_W-1:0]         snap_vy;
  logic        [N_PLAT*POS_W-1:0] snap_x;
  logic        [N_PLAT*POS_W-1:0] snap_y;
  logic        [N_PLAT*LEN_W-1:0] snap_len;
  logic        [IDX_W-1:0]        idx;

  logic                           cand_hit;
  logic        [POS_W-1:0]        cand_y;
  logic        [IDX_W-1:0]        cand_idx;

  logic        [POS_W-1:0]        slot_px;
  logic        [POS_W-1:0]        slot_py;
  logic        [LEN_W-1:0]        slot_len;
  logic                           slot_hit;
  logic        [POS_W-1:0]        slot_top;

  assign slot_px  = snap_x[idx*POS_W +: POS_W];
  assign slot_py  = snap_y[idx*POS_W +: POS_W];
  assign slot_len = snap_len[idx*LEN_W +: LEN_W];

  plat_slot_check u_slot_check (
    .char_x  (snap_cx),
    .char_y  (snap_cy),
    .char_vy (snap_vy),
    .px      (slot_px),
    .py      (slot_py),
    .len     (slot_len),
    .hit     (slot_hit),
    .top     (slot_top)
  );

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= ST_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves state_next unassigned (no latch).
    state_next = state;
    unique case (state)
      ST_IDLE: if (start)            state_next = ST_SCAN;
      ST_SCAN: if (idx == LAST_IDX)  state_next = ST_DONE;
      ST_DONE:                       state_next = ST_IDLE;
      default:                       state_next = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      snap_cx  <= '0;
      snap_cy  <= '0;
      snap_vy  <= '0;
      snap_x   <= '0;
      snap_y   <= '0;
      snap_len <= '0;
      idx      <= '0;
      cand_hit <= 1'b0;
      cand_y   <= '0;
      cand_idx <= '0;
      done     <= 1'b0;
      land_hit <= 1'b0;
      land_y   <= '0;
      land_idx <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            snap_cx  <= char_x;
            snap_cy  <= char_y;
            snap_vy  <= char_vy;
            snap_x   <= plat_abs_x;
            snap_y   <= plat_abs_y;
            snap_len <= plat_len;
            idx      <= '0;
            cand_hit <= 1'b0;
            cand_y   <= '0;
            cand_idx <= '0;
          end
        end
        ST_SCAN: begin
          // Strictly greater keeps the lowest index among equal tops.
          if (slot_hit && (!cand_hit || slot_top > cand_y)) begin
            cand_hit <= 1'b1;
            cand_y   <= slot_top;
            cand_idx <= idx;
          end
          if (idx != LAST_IDX) idx <= idx + 1'b1;
        end
        ST_DONE: begin
          done     <= 1'b1;
          land_hit <= cand_hit;
          land_y   <= cand_y;
          land_idx <= cand_idx;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_plat_landing_scan.sv
// Directed bench for plat_landing_scan: expected results are queued at start
// and compared when done pulses.
module tb_plat_landing_scan;
  import plat_landing_scan_pkg::*;

  logic                      sys_clk = 1'b0;
  logic                      sys_rst;
  logic                      start;
  logic        [POS_W-1:0]   char_x;
  logic        [POS_W-1:0]   char_y;
  logic signed [VY_W-1:0]    char_vy;
  logic [N_PLAT*POS_W-1:0]   plat_abs_x;
  logic [N_PLAT*POS_W-1:0]   plat_abs_y;
  logic [N_PLAT*LEN_W-1:0]   plat_len;
  logic                      busy;
  logic                      done;
  logic                      land_hit;
  logic        [POS_W-1:0]   land_y;
  logic        [IDX_W-1:0]   land_idx;

  typedef struct {
    logic             hit;
    logic [POS_W-1:0] y;
    logic [IDX_W-1:0] idx;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   k;

  plat_landing_scan dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .start      (start),
    .char_x     (char_x),
    .char_y     (char_y),
    .char_vy    (char_vy),
    .plat_abs_x (plat_abs_x),
    .plat_abs_y (plat_abs_y),
    .plat_len   (plat_len),
    .busy       (busy),
    .done       (done),
    .land_hit   (land_hit),
    .land_y     (land_y),
    .land_idx   (land_idx)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic clear_slots();
    plat_abs_x = '0;
    plat_abs_y = '0;
    plat_len   = '0;
  endtask

  task automatic set_slot(input int i, input int x, input int y, input int len);
    plat_abs_x[i*POS_W +: POS_W] = POS_W'(x);
    plat_abs_y[i*POS_W +: POS_W] = POS_W'(y);
    plat_len[i*LEN_W +: LEN_W]   = LEN_W'(len);
  endtask

  task automatic set_char(input int x, input int y, input int vy);
    char_x  = POS_W'(x);
    char_y  = POS_W'(y);
    char_vy = VY_W'(vy);
  endtask

  // Pulse start for one cycle; returns at the negedge after the sampling edge (k=0).
  task automatic launch(input string tag, input logic push, input logic h,
                        input int y, input int idx);
    exp_t e;
    @(negedge sys_clk);
    start = 1'b1;
    if (push) begin
      e.hit = h;
      e.y   = POS_W'(y);
      e.idx = IDX_W'(idx);
      sb.push_back(e);
    end
    @(negedge sys_clk);
    start = 1'b0;
    k = 0;
    check({tag, "_busy"}, busy, 1);
  endtask

  task automatic wait_done(input string tag);
    exp_t e;
    while (!done && k < 40) begin
      @(negedge sys_clk);
      k++;
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_lat"}, k, 8);
    check({tag, "_busy_end"}, busy, 0);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      check({tag, "_hit"}, land_hit, e.hit);
      check({tag, "_y"},   land_y,   e.y);
      check({tag, "_idx"}, land_idx, e.idx);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk);
      k++;
    end
  endtask

  initial begin
    int extra_done;

    sys_rst = 1'b1;
    start   = 1'b0;
    set_char(0, 0, 0);
    clear_slots();
    @(negedge sys_clk);
    @(negedge sys_clk);
    check("rst_busy",     busy,     0);
    check("rst_done",     done,     0);
    check("rst_land_hit", land_hit, 0);
    check("rst_land_y",   land_y,   0);
    check("rst_land_idx", land_idx, 0);
    sys_rst = 1'b0;

    // Basic landing on slot 0.
    set_char(100, 200, -4);
    set_slot(0, 96, 198, 2);
    launch("basic", 1, 1, 198, 0);
    wait_done("basic");

    // Rising character never lands.
    set_char(100, 200, 3);
    launch("rising", 1, 0, 0, 0);
    wait_done("rising");

    // Right edge of character exactly touches platform left edge: miss, then one pixel in: hit.
    set_char(80, 200, -4);
    launch("left_miss", 1, 0, 0, 0);
    wait_done("left_miss");
    set_char(81, 200, -4);
    launch("left_hit", 1, 1, 198, 0);
    wait_done("left_hit");

    // Character left edge at platform right edge (96+32=128): miss, 127: hit.
    set_char(128, 200, -4);
    launch("right_miss", 1, 0, 0, 0);
    wait_done("right_miss");
    set_char(127, 200, -4);
    launch("right_hit", 1, 1, 198, 0);
    wait_done("right_hit");

    // Fall through y=0: char_y+vy negative still crosses a top of 0.
    clear_slots();
    set_slot(0, 96, 0, 2);
    set_char(100, 3, -32);
    launch("neg_y", 1, 1, 0, 0);
    wait_done("neg_y");

    // Two hits: higher top wins; on a tie the lower index wins.
    clear_slots();
    set_slot(2, 96, 198, 2);
    set_slot(5, 96, 199, 2);
    set_char(100, 200, -5);
    launch("two_hi", 1, 1, 199, 5);
    wait_done("two_hi");
    set_slot(5, 96, 198, 2);
    launch("two_tie", 1, 1, 198, 2);
    wait_done("two_tie");

    // Restart attempt and platform change mid-scan: result comes from the snapshot.
    set_slot(5, 96, 199, 2);
    launch("snap", 1, 1, 199, 5);
    step(3);
    start = 1'b1;
    set_slot(2, 96, 150, 2);
    set_slot(5, 96, 150, 2);
    step(1);
    start = 1'b0;
    wait_done("snap");
    extra_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge sys_clk);
      if (done || busy) extra_done++;
    end
    check("snap_no_restart", extra_done, 0);

    // Reset in the middle of a scan aborts it with no done pulse.
    set_char(100, 200, -4);
    clear_slots();
    set_slot(0, 96, 198, 2);
    launch("abort", 0, 0, 0, 0);
    step(4);
    sys_rst = 1'b1;
    #1;
    check("abort_busy",     busy,     0);
    check("abort_done",     done,     0);
    check("abort_land_hit", land_hit, 0);
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    extra_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge sys_clk);
      if (done) extra_done++;
    end
    check("abort_no_done", extra_done, 0);

    // Fresh scan after the abort.
    launch("after_rst", 1, 1, 198, 0);
    wait_done("after_rst");
    check("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/plat_landing_scan.md
Name: plat_landing_scan

Overview:
- Reads the packed platform list written by the platform generator. Decides whether the character's next vertical step lands it on a platform.
- Sits between the platform generator and the character physics. The character raises a scan request each character tick and consumes the landing result before applying gravity.
- The scan is sequential: one platform slot per clock, so the compare datapath is shared.

Parameters:
- N_PLAT, 7, number of platform slots in the packed list.
- POS_W, 14, width of absolute x/y coordinates.
- LEN_W, 4, width of platform length field (length in blocks).
- BLOCK_PX, 16, pixel width of one platform block (power of two).
- CHAR_W, 16, character hitbox width in pixels.
- VY_W, 6, width of signed vertical velocity.

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle scan request. Ignored while busy.
- char_x  in  POS_W  absolute x of character hitbox left edge.
- char_y  in  POS_W  absolute y of character feet (y grows upward).
- char_vy  in  VY_W  signed vertical velocity per tick (negative = falling).
- plat_abs_x  in  N_PLAT*POS_W  packed platform left edges; slot i at bits [i*POS_W +: POS_W].
- plat_abs_y  in  N_PLAT*POS_W  packed platform top surfaces.
- plat_len  in  N_PLAT*LEN_W  packed lengths in blocks; 0 = slot empty.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse when the result is valid.
- land_hit  out  1  landing detected.
- land_y  out  POS_W  top surface of the chosen platform.
- land_idx  out  3  slot index of the chosen platform.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; internal best-candidate registers cleared.
- FSM states: IDLE, SCAN, DONE.
  - IDLE: on start, snapshot char_x, char_y, char_vy and all three packed vectors into registers. Clear the candidate. Set idx=0. Go to SCAN.
  - SCAN: evaluate slot idx from the snapshot, one slot per cycle. After idx = N_PLAT-1, go to DONE.
  - DONE: drive done=1 for exactly one cycle. Register land_hit, land_y, land_idx from the candidate. Return to IDLE.
- Latency: start sampled at edge 0; done is high during the cycle after edge N_PLAT+1 (8 cycles for the defaults).
- busy is high in SCAN and DONE.
- start while busy is ignored; no queueing.
- Input changes after the start cycle do not affect the result, because of the snapshot.
- Slot hit condition (all of the following):
  - len != 0;
  - char_vy < 0;
  - horizontal overlap: char_x + CHAR_W > px and char_x < px + len*BLOCK_PX, where px = plat_abs_x[i];
  - vertical crossing: char_y >= top and char_y + char_vy <= top, where top = plat_abs_y[i].
- Arithmetic width rules:
  - Horizontal sums are computed at POS_W+1 bits, so there is no wrap at the right edge.
  - len*BLOCK_PX is a shift.
  - char_y + char_vy uses a sign-extended POS_W+1-bit signed add. A negative result counts as crossing any top >= 0.
- Candidate selection:
  - The highest top among hits wins.
  - On equal top, the lowest index wins (replace only on strictly greater).
- Results hold until the next DONE.
- land_y and land_idx are 0 when land_hit=0.
- char_vy >= 0 (rising or still) means no hit on any slot.
- Reset asserted mid-scan: immediate return to IDLE with all outputs 0. The next start begins a fresh scan.

Decomposition:
- Shared package holds:
  - N_PLAT, POS_W and LEN_W constants (shared with the platform generator and the character);
  - BLOCK_PX and CHAR_W;
  - FSM state encoding.
- One natural sub-module: plat_slot_check, a combinational per-slot hit test. Inputs: snapshot char fields and one slot. Outputs: hit and top.

Test Plan:
- Single platform, char_x=100, char_y=200, char_vy=-4; slot0 at x=96, y=198, len=2; other slots len=0 -> done 8 cycles after start, land_hit=1, land_y=198, land_idx=0.
- Same setup with char_vy=+3 -> land_hit=0, land_y=0, land_idx=0 at done.
- Edge overlap, char_x=80 (right edge 96); slot at x=96 -> miss. Then char_x=81 -> hit.
- Two hits: slot2 top=198 and slot5 top=199, char_y=200, char_vy=-5 -> land_idx=5, land_y=199. Then slot5 top set to 198 -> land_idx=2.
- start pulsed again 3 cycles into a scan, and plat_abs_y changed mid-scan -> no restart, done at original time, result from the snapshot.
- sys_rst asserted at cycle 4 of a scan -> busy, done and land_hit drop to 0 asynchronously. No done pulse. A new start yields a correct result.
